// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write arbiter.
//   REG_W    : register number width
//   DATA_W   : register data width
//   NUM_REGS : architectural register count
//   wr_req_t : one write request {regnum, data, live}
package regfile_pkg;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REG_W-1:0]  regnum;
        logic [DATA_W-1:0] data;
        logic              live;
    } wr_req_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
        reg_onehot    = '0;
        reg_onehot[r] = 1'b1;
    endfunction
endpackage

// File: rtl/regfile_wr_fifo.sv
// Buffer for multdiv results that lost write-port arbitration.
// Each entry carries a live bit; a kill-by-register input clears the live bit
// of every occupied entry aimed at that register, so a stale result drains
// without writing. Live bits are cleared on pop, so entry_live is only ever
// set on occupied slots.
// Ports:
//   clock, reset_n        : clock, synchronous active-low reset
//   push, push_req        : enqueue request (ignored when full)
//   pop                   : dequeue head (ignored when empty)
//   kill_en, kill_reg     : clear live on entries targeting kill_reg
//   head                  : current head entry
//   count, empty          : occupancy (live or killed)
//   entry_reg, entry_live : per-slot register number and live bit
module regfile_wr_fifo
    import regfile_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push,
    input  wr_req_t                      push_req,
    input  logic                         pop,
    input  logic                         kill_en,
    input  logic [REG_W-1:0]             kill_reg,
    output wr_req_t                      head,
    output logic [PTR_W:0]               count,
    output logic                         empty,
    output logic [DEPTH-1:0][REG_W-1:0]  entry_reg,
    output logic [DEPTH-1:0]             entry_live
);
    logic [PTR_W-1:0]               rd_ptr;
    logic [PTR_W-1:0]               wr_ptr;
    logic [PTR_W:0]                 cnt;
    logic [DEPTH-1:0]               live_q;
    logic [DEPTH-1:0][REG_W-1:0]    reg_mem;
    logic [DEPTH-1:0][DATA_W-1:0]   data_mem;
    logic                           full;
    logic                           push_ok;
    logic                           pop_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PTR_W+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Payload needs no reset: it is only observed through live bits and count.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            reg_mem[wr_ptr]  <= push_req.regnum;
            data_mem[wr_ptr] <= push_req.data;
        end
    end

    // Kill first, then pop, then push: the pushed slot is never an occupied
    // one, so its live bit comes solely from push_req.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            live_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && (reg_mem[i] == kill_reg))
                    live_q[i] <= 1'b0;
            end
            if (pop_ok) begin
                live_q[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                live_q[wr_ptr] <= push_req.live;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_comb begin
        head.regnum = reg_mem[rd_ptr];
        head.data   = data_mem[rd_ptr];
        head.live   = live_q[rd_ptr];
    end

    assign count      = cnt;
    assign entry_reg  = reg_mem;
    assign entry_live = live_q;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter. Merges the pipeline writeback (fixed
// priority, never stalls) with multdiv completions (valid/ready) into one
// registered write port. Losing multdiv results wait in regfile_wr_fifo;
// a newer pipeline write to the same register kills buffered entries.
// Writes to register 0 are never issued.
// Build option: define MD_BYPASS_EN to let a live multdiv result go straight
// to the output register when the buffer is empty and the pipeline is idle.
// Ports:
//   clock, reset_n                 : clock, synchronous active-low reset
//   wb_valid, wb_reg, wb_data      : pipeline writeback
//   md_valid, md_reg, md_data      : multdiv result offer
//   md_ready                       : multdiv result accepted
//   ctrl_writeEnable/ctrl_writeReg : registered write enable / register
//   data_writeReg                  : registered write data
//   pending_mask                   : registers targeted by live buffered entries
//   md_count                       : buffer occupancy
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                wb_valid,
    input  logic [REG_W-1:0]    wb_reg,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                md_valid,
    input  logic [REG_W-1:0]    md_reg,
    input  logic [DATA_W-1:0]   md_data,
    output logic                md_ready,
    output logic                ctrl_writeEnable,
    output logic [REG_W-1:0]    ctrl_writeReg,
    output logic [DATA_W-1:0]   data_writeReg,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [PTR_W:0]      md_count
);
    logic                           wb_req;
    logic                           md_acc;
    logic                           md_live;
    logic                           bypass;
    logic                           push;
    logic                           pop;
    wr_req_t                        push_req;
    wr_req_t                        head;
    logic [PTR_W:0]                 fifo_count;
    logic                           fifo_empty;
    logic [DEPTH-1:0][REG_W-1:0]    entry_reg;
    logic [DEPTH-1:0]               entry_live;
    logic                           nxt_we;
    logic [REG_W-1:0]               nxt_reg;
    logic [DATA_W-1:0]              nxt_data;
    logic [NUM_REGS-1:0]            pend;

    // A write to $0 is no request at all.
    assign wb_req   = wb_valid && (wb_reg != '0);
    // Ready looks only at occupancy: a full buffer stays closed even on a
    // cycle where it pops.
    assign md_ready = (fifo_count != (PTR_W+1)'(DEPTH)) && reset_n;
    assign md_acc   = md_valid && md_ready;
    // Born dead if aimed at $0 or overwritten by the pipeline this same cycle.
    assign md_live  = (md_reg != '0) && !(wb_valid && (wb_reg == md_reg));

`ifdef MD_BYPASS_EN
    assign bypass = fifo_empty && !wb_req && md_acc && md_live;
`else
    assign bypass = 1'b0;
`endif

    assign push = md_acc && !bypass;
    // Killed heads are popped too; they just consume the cycle.
    assign pop  = !wb_req && !fifo_empty;

    always_comb begin
        push_req.regnum = md_reg;
        push_req.data   = md_data;
        push_req.live   = md_live;
    end

    regfile_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_req   (push_req),
        .pop        (pop),
        .kill_en    (wb_req),
        .kill_reg   (wb_reg),
        .head       (head),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .entry_reg  (entry_reg),
        .entry_live (entry_live)
    );

    // Priority: pipeline, then buffered head, then (optionally) bypass.
    // Register number and data hold when nothing is written.
    always_comb begin
        nxt_we   = 1'b0;
        nxt_reg  = ctrl_writeReg;
        nxt_data = data_writeReg;
        if (wb_req) begin
            nxt_we   = 1'b1;
            nxt_reg  = wb_reg;
            nxt_data = wb_data;
        end else if (!fifo_empty) begin
            if (head.live) begin
                nxt_we   = 1'b1;
                nxt_reg  = head.regnum;
                nxt_data = head.data;
            end
        end else if (bypass) begin
            nxt_we   = 1'b1;
            nxt_reg  = md_reg;
            nxt_data = md_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
        end else begin
            ctrl_writeEnable <= nxt_we;
            ctrl_writeReg    <= nxt_reg;
            data_writeReg    <= nxt_data;
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_live[i])
                pend = pend | reg_onehot(entry_reg[i]);
        end
        pend[0] = 1'b0;
    end

    assign pending_mask = pend;
    assign md_count     = fifo_count;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
    localparam int DEPTH = 4;
`ifdef MD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        md_valid;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic        md_ready;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] pending_mask;
    logic [2:0]  md_count;

    regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .wb_valid         (wb_valid),
        .wb_reg           (wb_reg),
        .wb_data          (wb_data),
        .md_valid         (md_valid),
        .md_reg           (md_reg),
        .md_data          (md_data),
        .md_ready         (md_ready),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .pending_mask     (pending_mask),
        .md_count         (md_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: buffered results as an ordered list; the write port as
    // three plain variables.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        bit          live;
    } ent_t;

    ent_t        mq[$];
    bit          m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    bit          rdy_seen;

    function automatic logic [31:0] model_pend();
        logic [31:0] p = '0;
        foreach (mq[i]) if (mq[i].live && mq[i].r != 0) p[mq[i].r] = 1'b1;
        return p;
    endfunction

    // Called just after a rising edge: drive, check ready, clock, update model, check.
    task automatic cycle(input bit rst, input bit wv, input logic [4:0] wr, input logic [31:0] wd,
                         input bit mv, input logic [4:0] mr, input logic [31:0] md);
        bit   exp_rdy, wbw, acc, byp, live;
        ent_t e;
        reset_n  = rst;
        wb_valid = wv;
        wb_reg   = wr;
        wb_data  = wd;
        md_valid = mv;
        md_reg   = mr;
        md_data  = md;
        #1;
        exp_rdy  = rst && (mq.size() != DEPTH);
        rdy_seen = md_ready;
        check("md_ready", 32'(md_ready), 32'(exp_rdy));
        @(posedge clock);
        #1;
        if (!rst) begin
            mq.delete();
            m_we = 0; m_reg = '0; m_data = '0;
        end else begin
            wbw  = wv && (wr != 0);
            acc  = mv && exp_rdy;
            live = (mr != 0) && !(wv && wr == mr);
            byp  = 0;
            if (wbw) foreach (mq[i]) if (mq[i].r == wr) mq[i].live = 0;
            if (wbw) begin
                m_we = 1; m_reg = wr; m_data = wd;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_we = e.live;
                if (e.live) begin m_reg = e.r; m_data = e.d; end
            end else if (BYPASS && acc && live) begin
                m_we = 1; m_reg = mr; m_data = md; byp = 1;
            end else begin
                m_we = 0;
            end
            if (acc && !byp) mq.push_back('{r: mr, d: md, live: live});
        end
        check("write_enable", 32'(ctrl_writeEnable), 32'(m_we));
        check("write_reg",    32'(ctrl_writeReg),    32'(m_reg));
        check("write_data",   data_writeReg,         m_data);
        check("md_count",     32'(md_count),         32'(mq.size()));
        check("pending_mask", pending_mask,          model_pend());
    endtask

    typedef struct {
        bit          rst;
        bit          wv;
        logic [4:0]  wr;
        logic [31:0] wd;
        bit          mv;
        logic [4:0]  mr;
        logic [31:0] md;
        bit          e_we;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        int          e_cnt;
        logic [31:0] e_pend;
        bit          e_rdy;
    } vec_t;

    vec_t tbl[15];

    initial begin
        reset_n = 0; wb_valid = 0; wb_reg = '0; wb_data = '0;
        md_valid = 0; md_reg = '0; md_data = '0;
        m_we = 0; m_reg = '0; m_data = '0; rdy_seen = 0;

        //          rst wv wr  wd            mv mr  md      we reg data          cnt pend         rdy
        tbl[0]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h0,        0, 32'h0,      0};
        tbl[1]  = '{1, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,  1, 5, 32'hDEADBEEF, 0, 32'h0,      1};
        tbl[2]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,  0, 5, 32'hDEADBEEF, 0, 32'h0,      1};
        tbl[3]  = '{1, 1, 3, 32'hA0,       1, 7, 32'h11, 1, 3, 32'hA0,       1, 32'h80,     1};
        tbl[4]  = '{1, 1, 3, 32'hA1,       0, 0, 32'h0,  1, 3, 32'hA1,       1, 32'h80,     1};
        tbl[5]  = '{1, 1, 3, 32'hA2,       0, 0, 32'h0,  1, 3, 32'hA2,       1, 32'h80,     1};
        tbl[6]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,  1, 7, 32'h11,       0, 32'h0,      1};
        tbl[7]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,  0, 7, 32'h11,       0, 32'h0,      1};
        tbl[8]  = '{1, 1, 4, 32'hB0,       1, 9, 32'h99, 1, 4, 32'hB0,       1, 32'h200,    1};
        tbl[9]  = '{1, 1, 9, 32'h900D,     0, 0, 32'h0,  1, 9, 32'h900D,     1, 32'h0,      1};
        tbl[10] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,  0, 9, 32'h900D,     0, 32'h0,      1};
        tbl[11] = '{1, 1, 0, 32'h55,       1, 0, 32'h66, 0, 9, 32'h900D,     1, 32'h0,      1};
        tbl[12] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,  0, 9, 32'h900D,     0, 32'h0,      1};
        tbl[13] = '{1, 1, 6, 32'h60,       1, 6, 32'h61, 1, 6, 32'h60,       1, 32'h0,      1};
        tbl[14] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,  0, 6, 32'h60,       0, 32'h0,      1};

        @(posedge clock);
        #1;

        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].rst, tbl[i].wv, tbl[i].wr, tbl[i].wd, tbl[i].mv, tbl[i].mr, tbl[i].md);
            check($sformatf("vec%0d_ready", i), 32'(rdy_seen),         32'(tbl[i].e_rdy));
            check($sformatf("vec%0d_we",    i), 32'(ctrl_writeEnable), 32'(tbl[i].e_we));
            check($sformatf("vec%0d_reg",   i), 32'(ctrl_writeReg),    32'(tbl[i].e_reg));
            check($sformatf("vec%0d_data",  i), data_writeReg,         tbl[i].e_data);
            check($sformatf("vec%0d_count", i), 32'(md_count),         32'(tbl[i].e_cnt));
            check($sformatf("vec%0d_pend",  i), pending_mask,          tbl[i].e_pend);
        end

        // Fill the buffer under continuous pipeline traffic.
        for (int i = 0; i < DEPTH; i++)
            cycle(1, 1, 5'd1, 32'(i), 1, 5'(10 + i), 32'(100 + i));
        check("fill_count", 32'(md_count), 32'(DEPTH));
        cycle(1, 1, 5'd1, 32'h77, 1, 5'd20, 32'h200);
        check("full_ready", 32'(rdy_seen), 32'd0);
        check("full_count", 32'(md_count), 32'(DEPTH));
        // Pipeline idle: head drains, but a full buffer does not reopen this cycle.
        cycle(1, 0, 5'd0, 32'h0, 1, 5'd20, 32'h200);
        check("full_no_passthru", 32'(rdy_seen), 32'd0);
        check("after_pop_count", 32'(md_count), 32'(DEPTH - 1));
        check("after_pop_reg", 32'(ctrl_writeReg), 32'd10);
        cycle(1, 0, 5'd0, 32'h0, 1, 5'd20, 32'h200);
        check("reopen_ready", 32'(rdy_seen), 32'd1);
        check("push_pop_count", 32'(md_count), 32'(DEPTH - 1));
        for (int i = 0; i < 6; i++) cycle(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        check("drained_count", 32'(md_count), 32'd0);

        // Reset with three buffered results: none may ever be written.
        for (int i = 0; i < 3; i++)
            cycle(1, 1, 5'd2, 32'(i), 1, 5'(21 + i), 32'(300 + i));
        check("pre_reset_count", 32'(md_count), 32'd3);
        cycle(0, 0, 5'd0, 32'h0, 1, 5'd25, 32'h400);
        check("reset_count", 32'(md_count), 32'd0);
        check("reset_pend", pending_mask, 32'd0);
        check("reset_we", 32'(ctrl_writeEnable), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
            check("no_stale_write", 32'(ctrl_writeEnable), 32'd0);
        end

        // Random traffic on a small register range to force collisions.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 63) != 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
